// File: rtl/rv_mem_pkg.sv
// Shared types for the data-memory load/store path.
// Access codes, LSU states and small decode helpers.
package rv_mem_pkg;

  typedef enum logic [3:0] {
    LB  = 4'd0,
    LH  = 4'd1,
    LW  = 4'd2,
    LBU = 4'd3,
    LHU = 4'd4,
    SB  = 4'd5,
    SH  = 4'd6,
    SW  = 4'd7
  } mem_ctrl_e;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    ERR
  } lsu_state_e;

  function automatic logic is_load(mem_ctrl_e c);
    return c <= LHU;
  endfunction

  function automatic logic is_store(mem_ctrl_e c);
    return c inside {SB, SH, SW};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit.
// Builds enables, store lanes, load extension, alignment.
module lsu_align
  import rv_mem_pkg::*;
(
  input  logic [3:0]  mem_ctrl,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  output logic [31:0] ext_rdata,
  output logic        misaligned
);

  mem_ctrl_e   c;
  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        sgn;
  logic [4:0]  sh;
  logic [31:0] lane;

  assign c    = mem_ctrl_e'(mem_ctrl);
  assign is_b = (c == LB) | (c == LBU) | (c == SB);
  assign is_h = (c == LH) | (c == LHU) | (c == SH);
  assign is_w = (c == LW) | (c == SW);
  assign sgn  = (c == LB) | (c == LH);
  assign sh   = {addr, 3'b000};
  assign lane = bus_rdata >> sh;

  // Lane enables, store replication and load extension by size
  always_comb begin
    bus_be     = 4'b0000;
    bus_wdata  = 32'h0;
    ext_rdata  = 32'h0;
    misaligned = 1'b0;
    unique case (1'b1)
      is_b: begin
        bus_be    = 4'b0001 << addr;
        bus_wdata = {4{wdata[7:0]}};
        ext_rdata = {{24{sgn & lane[7]}}, lane[7:0]};
      end
      is_h: begin
        misaligned = addr[0];
        bus_be     = 4'b0011 << addr;
        bus_wdata  = {2{wdata[15:0]}};
        ext_rdata  = {{16{sgn & lane[15]}}, lane[15:0]};
      end
      is_w: begin
        misaligned = |addr;
        bus_be     = 4'b1111;
        bus_wdata  = wdata;
        ext_rdata  = bus_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one aligned access over req/gnt/rvalid.
// Stalls the core until done; aborts on misalign/timeout.
module load_store_unit
  import rv_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [3:0]  mem_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state;
  logic [3:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [CW-1:0] cnt;

  logic        req;
  logic        legal;
  logic        go;
  logic        tmo;
  logic        in_idle;
  logic [3:0]  a_ctrl;
  logic [1:0]  a_addr;
  logic [3:0]  a_be;
  logic [31:0] a_wdata;
  logic [31:0] a_ext;
  logic        a_mis;

  assign in_idle = (state == IDLE);
  assign req     = mem_r | mem_w;
  assign legal   = mem_w ? is_store(mem_ctrl_e'(mem_ctrl))
                         : is_load(mem_ctrl_e'(mem_ctrl));
  assign go      = req & legal;
  assign tmo     = (cnt == T_LAST);

  // Live inputs are checked in IDLE; latched ones drive the bus
  assign a_ctrl = in_idle ? mem_ctrl : op_q;
  assign a_addr = in_idle ? addr[1:0] : addr_q[1:0];

  lsu_align u_align (
    .mem_ctrl   (a_ctrl),
    .addr       (a_addr),
    .wdata      (wdata_q),
    .bus_rdata  (bus_rdata),
    .bus_be     (a_be),
    .bus_wdata  (a_wdata),
    .ext_rdata  (a_ext),
    .misaligned (a_mis)
  );

  assign stall = (in_idle & go)
               | (state == REQ)
               | (state == WAIT);

  assign bus_we    = bus_req & we_q;
  assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus_be    = bus_req ? a_be : 4'b0000;
  assign bus_wdata = bus_req ? a_wdata : 32'h0;

  // Access FSM with operand latches and timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= 4'h0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      we_q      <= 1'b0;
      cnt       <= '0;
      bus_req   <= 1'b0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      load_data <= 32'h0;
    end else begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            op_q    <= mem_ctrl;
            addr_q  <= addr;
            wdata_q <= wdata;
            we_q    <= mem_w;
            if (a_mis) begin
              state    <= ERR;
              misalign <= 1'b1;
            end else begin
              state   <= REQ;
              bus_req <= 1'b1;
              cnt     <= '0;
            end
          end
        end
        REQ: begin
          if (bus_gnt) begin
            bus_req <= 1'b0;
            cnt     <= cnt + 1'b1;
            state   <= we_q ? DONE : WAIT;
          end else if (tmo) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
          if (bus_rvalid) begin
            load_data <= a_ext;
            state     <= DONE;
          end else if (tmo) begin
            bus_err <= 1'b1;
            state   <= ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit.
// Hand-computed vectors for stores, loads and error paths.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r;
  logic        mem_w;
  logic [3:0]  mem_ctrl;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        misalign;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  int          ns;
  int          nr;
  logic [3:0]  s_be;
  logic [31:0] s_wd;
  logic [31:0] s_ad;
  logic        s_we;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_r      (mem_r),
    .mem_w      (mem_w),
    .mem_ctrl   (mem_ctrl),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .load_data  (load_data),
    .misalign   (misalign),
    .bus_err    (bus_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_r = 1'b0;
    mem_w = 1'b0;
    step();
  endtask

  // Issue one op, hold it while stalled, record the first bus beat
  task automatic run_op(input logic r, input logic w,
                        input logic [3:0] c,
                        input logic [31:0] a,
                        input logic [31:0] d);
    mem_r    = r;
    mem_w    = w;
    mem_ctrl = c;
    addr     = a;
    wdata    = d;
    #1;
    ns = 0;
    nr = 0;
    s_be = 4'h0;
    s_wd = 32'h0;
    s_ad = 32'h0;
    s_we = 1'b0;
    while (stall && ns < 200) begin
      if (bus_req) begin
        if (nr == 0) begin
          s_be = bus_be;
          s_wd = bus_wdata;
          s_ad = bus_addr;
          s_we = bus_we;
        end
        nr++;
      end
      step();
      ns++;
    end
    if (ns >= 200) chk("stall_bound", 32'(ns), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    mem_r      = 1'b0;
    mem_w      = 1'b0;
    mem_ctrl   = 4'h0;
    addr       = 32'h0;
    wdata      = 32'h0;
    bus_gnt    = 1'b1;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h0;
    step();
    step();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_ld", load_data, 32'h0);
    chk("rst_err", {misalign, bus_err}, 32'd0);
    rst = 1'b0;
    step();

    run_op(1'b0, 1'b1, 4'd7, 32'h104, 32'hDEADBEEF);
    chk("sw_stall", 32'(ns), 32'd2);
    chk("sw_we", 32'(s_we), 32'd1);
    chk("sw_be", 32'(s_be), 32'hF);
    chk("sw_addr", s_ad, 32'h104);
    chk("sw_wd", s_wd, 32'hDEADBEEF);
    chk("sw_done_req", 32'(bus_req), 32'd0);
    idle();

    run_op(1'b0, 1'b1, 4'd5, 32'h103, 32'h000000A5);
    chk("sb_stall", 32'(ns), 32'd2);
    chk("sb_be", 32'(s_be), 32'h8);
    chk("sb_lane", 32'(s_wd[31:24]), 32'hA5);
    chk("sb_addr", s_ad, 32'h100);
    idle();

    bus_rdata = 32'h00800000;
    run_op(1'b1, 1'b0, 4'd0, 32'h102, 32'h0);
    chk("lb_stall", 32'(ns), 32'd3);
    chk("lb_we", 32'(s_we), 32'd0);
    chk("lb_be", 32'(s_be), 32'h4);
    chk("lb_data", load_data, 32'hFFFFFF80);
    idle();
    chk("lb_hold", load_data, 32'hFFFFFF80);

    run_op(1'b1, 1'b0, 4'd3, 32'h102, 32'h0);
    chk("lbu_data", load_data, 32'h00000080);
    idle();

    bus_rdata = 32'h80010000;
    run_op(1'b1, 1'b0, 4'd1, 32'h102, 32'h0);
    chk("lh_be", 32'(s_be), 32'hC);
    chk("lh_data", load_data, 32'hFFFF8001);
    idle();
    run_op(1'b1, 1'b0, 4'd4, 32'h102, 32'h0);
    chk("lhu_data", load_data, 32'h00008001);
    idle();

    run_op(1'b1, 1'b0, 4'd1, 32'h101, 32'h0);
    chk("mis_stall", 32'(ns), 32'd1);
    chk("mis_noreq", 32'(nr), 32'd0);
    chk("mis_pulse", 32'(misalign), 32'd1);
    chk("mis_noerr", 32'(bus_err), 32'd0);
    idle();
    chk("mis_clear", 32'(misalign), 32'd0);
    chk("mis_nostall", 32'(stall), 32'd0);

    bus_gnt = 1'b0;
    run_op(1'b1, 1'b0, 4'd2, 32'h200, 32'h0);
    chk("tmo_stall", 32'(ns), 32'd65);
    chk("tmo_reqcyc", 32'(nr), 32'd64);
    chk("tmo_pulse", 32'(bus_err), 32'd1);
    chk("tmo_reqdrop", 32'(bus_req), 32'd0);
    idle();
    chk("tmo_clear", 32'(bus_err), 32'd0);
    chk("tmo_nostall", 32'(stall), 32'd0);
    bus_gnt   = 1'b1;
    bus_rdata = 32'h12345678;
    run_op(1'b1, 1'b0, 4'd2, 32'h200, 32'h0);
    chk("lw_stall", 32'(ns), 32'd3);
    chk("lw_data", load_data, 32'h12345678);
    idle();

    run_op(1'b1, 1'b0, 4'd5, 32'h100, 32'h0);
    chk("ill_ld_stall", 32'(ns), 32'd0);
    step();
    chk("ill_ld_req", 32'(bus_req), 32'd0);
    idle();
    run_op(1'b0, 1'b1, 4'd9, 32'h100, 32'h0);
    chk("ill_st_stall", 32'(ns), 32'd0);
    step();
    chk("ill_st_req", 32'(bus_req), 32'd0);
    idle();

    run_op(1'b1, 1'b1, 4'd6, 32'h106, 32'h0000BEEF);
    chk("rw_we", 32'(s_we), 32'd1);
    chk("rw_be", 32'(s_be), 32'hC);
    chk("rw_wd", s_wd, 32'hBEEFBEEF);
    chk("rw_ld_kept", load_data, 32'h12345678);
    idle();

    bus_rvalid = 1'b0;
    mem_r    = 1'b1;
    mem_ctrl = 4'd2;
    addr     = 32'h300;
    step();
    step();
    chk("wait_stall", 32'(stall), 32'd1);
    chk("wait_req", 32'(bus_req), 32'd0);
    rst   = 1'b1;
    mem_r = 1'b0;
    step();
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_req", 32'(bus_req), 32'd0);
    chk("rst_mid_ld", load_data, 32'h0);
    chk("rst_mid_pulse", {misalign, bus_err}, 32'd0);
    rst        = 1'b0;
    bus_rvalid = 1'b1;
    step();
    chk("post_rst_req", 32'(bus_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
